// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter: FSM states,
// owner encoding and the width of the latency and starvation counters.
package mem_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic {
    ST_IDLE,
    ST_ACCESS
  } state_t;

  typedef enum logic {
    OWN_IF,
    OWN_LS
  } owner_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Starvation counter: counts load/store wins while fetch waits and raises
// force_if once starve_limit consecutive wins have gone by. Used with MEM_ARB_STARVE_EN.
module mem_arb_starve_ctr
  import mem_arb_pkg::*;
#(
  parameter int starve_limit = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ls_win,
  input  logic if_req,
  input  logic if_win,
  input  logic idle,
  output logic force_if
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(starve_limit);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (idle) begin
      if (if_win || !if_req) begin
        cnt_q <= '0;
      end else if (ls_win && (cnt_q != LIMIT)) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign force_if = (cnt_q == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory_unit port between fetch (if_*) and load/store (ls_*) with a
// fixed access latency. Optional fetch anti-starvation under MEM_ARB_STARVE_EN.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int word_size    = 32,
  parameter int mem_latency  = 2,
  parameter int starve_limit = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 if_req,
  input  logic [word_size-1:0] if_addr,
  output logic                 if_gnt,
  output logic                 if_rvalid,
  output logic [word_size-1:0] if_rdata,
  input  logic                 ls_req,
  input  logic                 ls_we,
  input  logic [word_size-1:0] ls_addr,
  input  logic [word_size-1:0] ls_wdata,
  output logic                 ls_gnt,
  output logic                 ls_rvalid,
  output logic [word_size-1:0] ls_rdata,
  output logic [word_size-1:0] mem_addr,
  output logic [word_size-1:0] mem_wdata,
  output logic                 mem_read,
  output logic                 mem_write,
  input  logic [word_size-1:0] mem_rdata,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(mem_latency - 1);

  state_t                 state_q, state_d;
  owner_t                 owner_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [word_size-1:0]   addr_q, wdata_q;
  logic                   we_q;
  logic                   idle, if_win, ls_win;

  // Grants are gated by reset so every output reads 0 while rst is low.
  assign idle = (state_q == ST_IDLE) && rst;

`ifdef MEM_ARB_STARVE_EN
  logic force_if;

  mem_arb_starve_ctr #(
    .starve_limit(starve_limit)
  ) u_starve_ctr (
    .clk     (clk),
    .rst     (rst),
    .ls_win  (ls_win),
    .if_req  (if_req),
    .if_win  (if_win),
    .idle    (idle),
    .force_if(force_if)
  );

  assign if_win = idle && if_req && (!ls_req || force_if);
  assign ls_win = idle && ls_req && !if_win;
`else
  logic unused_ok;
  assign unused_ok = ^(CNT_W'(starve_limit));

  assign ls_win = idle && ls_req;
  assign if_win = idle && if_req && !ls_req;
`endif

  assign if_gnt = if_win;
  assign ls_gnt = ls_win;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (if_win || ls_win) state_d = ST_ACCESS;
      ST_ACCESS: if (cnt_q == '0)      state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Request capture at grant; completion and rdata update at the last access edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q   <= OWN_IF;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      if_rdata  <= '0;
      ls_rdata  <= '0;
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
    end else begin
      if_rvalid <= 1'b0;
      ls_rvalid <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (ls_win) begin
          owner_q <= OWN_LS;
          addr_q  <= ls_addr;
          wdata_q <= ls_wdata;
          we_q    <= ls_we;
          cnt_q   <= LAT_LOAD;
        end else if (if_win) begin
          owner_q <= OWN_IF;
          addr_q  <= if_addr;
          we_q    <= 1'b0;
          cnt_q   <= LAT_LOAD;
        end
      end else if (cnt_q == '0) begin
        if (owner_q == OWN_IF) begin
          if_rdata  <= mem_rdata;
          if_rvalid <= 1'b1;
        end else begin
          if (!we_q) ls_rdata <= mem_rdata;
          ls_rvalid <= 1'b1;
        end
      end else begin
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_read  = (state_q == ST_ACCESS) && !we_q;
  assign mem_write = (state_q == ST_ACCESS) && we_q;
  assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small word memory behind the port.
// Starvation expectations follow MEM_ARB_STARVE_EN when it is defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req = 1'b0;
  logic        ls_we = 1'b0;
  logic [31:0] ls_addr = '0;
  logic [31:0] ls_wdata = '0;
  logic        ls_gnt, ls_rvalid;
  logic [31:0] ls_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write, busy;

  logic        pre_we = 1'b0;
  logic [5:0]  pre_idx = '0;
  logic [31:0] pre_data = '0;
  logic [31:0] mem [0:63];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:2]];

  always @(posedge clk) begin
    if (mem_write)   mem[mem_addr[7:2]] <= mem_wdata;
    else if (pre_we) mem[pre_idx]       <= pre_data;
  end

  mem_port_arbiter #(
    .word_size(32), .mem_latency(2), .starve_limit(4)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Advance to the next negative edge: inputs change there, checks follow #1 later.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  task automatic preload(input logic [5:0] idx, input logic [31:0] data);
    next_cycle();
    pre_idx = idx; pre_data = data; pre_we = 1'b1;
    next_cycle();
    pre_we = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 64; i++) preload(i[5:0], 32'h0);
    preload(6'h04, 32'h11223344);
    preload(6'h00, 32'hA0A0A0A0);
    preload(6'h01, 32'hB4B4B4B4);
    next_cycle();
    if_req = 1'b1; ls_req = 1'b1; #1;
    checks++; if ({if_gnt, ls_gnt} !== 2'b00) begin errors++; $display("FAIL reset_gnt got %b exp 00", {if_gnt, ls_gnt}); end
    checks++; if ({if_rvalid, ls_rvalid, mem_read, mem_write, busy} !== 5'b0) begin errors++; $display("FAIL reset_ctl got %b exp 00000", {if_rvalid, ls_rvalid, mem_read, mem_write, busy}); end
    checks++; if ({if_rdata, ls_rdata, mem_addr, mem_wdata} !== 128'h0) begin errors++; $display("FAIL reset_data got %h exp 0", {if_rdata, ls_rdata, mem_addr, mem_wdata}); end
    if_req = 1'b0; ls_req = 1'b0;
    next_cycle();
    rst = 1'b1;
    next_cycle();
  endtask

  task automatic test_fetch_read();
    if_req = 1'b1; if_addr = 32'h10; #1;
    checks++; if ({if_gnt, ls_gnt, busy} !== 3'b100) begin errors++; $display("FAIL fetch_gnt got %b exp 100", {if_gnt, ls_gnt, busy}); end
    for (int c = 1; c <= 2; c++) begin
      next_cycle(); if_req = 1'b0; #1;
      checks++; if ({mem_read, mem_write, busy, if_gnt} !== 4'b1010 || mem_addr !== 32'h10) begin
        errors++; $display("FAIL fetch_access c%0d got rd/wr/busy/gnt=%b addr=%h exp 1010 addr=00000010", c, {mem_read, mem_write, busy, if_gnt}, mem_addr);
      end
    end
    next_cycle(); #1;
    checks++; if ({if_rvalid, ls_rvalid, mem_read, busy} !== 4'b1000 || if_rdata !== 32'h11223344) begin
      errors++; $display("FAIL fetch_rvalid got v/lv/rd/busy=%b data=%h exp 1000 data=11223344", {if_rvalid, ls_rvalid, mem_read, busy}, if_rdata);
    end
    next_cycle(); #1;
    checks++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h11223344 || mem_addr !== 32'h10) begin
      errors++; $display("FAIL fetch_hold got v=%b data=%h addr=%h exp 0 11223344 00000010", if_rvalid, if_rdata, mem_addr);
    end
  endtask

  task automatic test_store_load();
    next_cycle();
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h20; ls_wdata = 32'hDEADBEEF; #1;
    checks++; if ({ls_gnt, if_gnt} !== 2'b10) begin errors++; $display("FAIL store_gnt got %b exp 10", {ls_gnt, if_gnt}); end
    for (int c = 1; c <= 2; c++) begin
      next_cycle(); ls_req = 1'b0; ls_wdata = 32'h0; #1;
      checks++; if ({mem_write, mem_read} !== 2'b10 || mem_wdata !== 32'hDEADBEEF || mem_addr !== 32'h20) begin
        errors++; $display("FAIL store_access c%0d got wr/rd=%b wdata=%h addr=%h exp 10 deadbeef 00000020", c, {mem_write, mem_read}, mem_wdata, mem_addr);
      end
    end
    next_cycle();
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h20; #1;
    checks++; if ({ls_rvalid, if_rvalid, mem_write} !== 3'b100 || ls_rdata !== 32'h0) begin
      errors++; $display("FAIL store_done got lv/iv/wr=%b rdata=%h exp 100 00000000", {ls_rvalid, if_rvalid, mem_write}, ls_rdata);
    end
    checks++; if (ls_gnt !== 1'b1) begin errors++; $display("FAIL load_overlap_gnt got %b exp 1", ls_gnt); end
    next_cycle(); ls_req = 1'b0; #1;
    checks++; if ({mem_read, mem_write} !== 2'b10) begin errors++; $display("FAIL load_access got %b exp 10", {mem_read, mem_write}); end
    next_cycle(); next_cycle(); #1;
    checks++; if (ls_rvalid !== 1'b1 || ls_rdata !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load_data got v=%b data=%h exp 1 deadbeef", ls_rvalid, ls_rdata);
    end
  endtask

  task automatic test_simultaneous();
    next_cycle();
    if_req = 1'b1; if_addr = 32'h0; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h4; #1;
    checks++; if ({ls_gnt, if_gnt} !== 2'b10) begin errors++; $display("FAIL simul_first got ls/if=%b exp 10", {ls_gnt, if_gnt}); end
    next_cycle(); ls_req = 1'b0;
    next_cycle();
    next_cycle(); #1;
    checks++; if ({ls_rvalid, if_gnt} !== 2'b11 || ls_rdata !== 32'hB4B4B4B4) begin
      errors++; $display("FAIL simul_ls_done got lv/ig=%b data=%h exp 11 b4b4b4b4", {ls_rvalid, if_gnt}, ls_rdata);
    end
    next_cycle(); if_req = 1'b0;
    next_cycle();
    next_cycle(); #1;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'hA0A0A0A0 || ls_rvalid !== 1'b0) begin
      errors++; $display("FAIL simul_if_done got iv=%b data=%h lv=%b exp 1 a0a0a0a0 0", if_rvalid, if_rdata, ls_rvalid);
    end
  endtask

  task automatic test_back_to_back();
    next_cycle();
    if_req = 1'b1; if_addr = 32'h10;
    for (int c = 0; c < 10; c++) begin
      logic exp_g;
      exp_g = (c % 3 == 0);
      #1;
      checks++; if (if_gnt !== exp_g || busy !== !exp_g) begin
        errors++; $display("FAIL b2b c%0d got gnt=%b busy=%b exp gnt=%b busy=%b", c, if_gnt, busy, exp_g, !exp_g);
      end
      next_cycle();
    end
    if_req = 1'b0;
    next_cycle(); next_cycle(); next_cycle();
  endtask

  task automatic test_starvation();
    int if_grants;
    logic [1:0] exp_g;
    if_grants = 0;
    next_cycle();
    if_req = 1'b1; if_addr = 32'h0; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h4;
    for (int k = 0; k < 6; k++) begin
      #1;
`ifdef MEM_ARB_STARVE_EN
      exp_g = (k == 4) ? 2'b01 : 2'b10;
`else
      exp_g = 2'b10;
`endif
      checks++; if ({ls_gnt, if_gnt} !== exp_g) begin
        errors++; $display("FAIL starve_grant k%0d got ls/if=%b exp %b", k, {ls_gnt, if_gnt}, exp_g);
      end
      for (int c = 0; c < 3; c++) begin
        if (if_gnt === 1'b1) if_grants++;
        next_cycle(); #1;
      end
    end
`ifdef MEM_ARB_STARVE_EN
    checks++; if (if_grants !== 1) begin errors++; $display("FAIL starve_if_count got %0d exp 1", if_grants); end
`else
    checks++; if (if_grants !== 0) begin errors++; $display("FAIL starve_if_count got %0d exp 0", if_grants); end
`endif
    if_req = 1'b0; ls_req = 1'b0;
    next_cycle(); next_cycle(); next_cycle();
  endtask

  task automatic test_reset_mid_access();
    next_cycle();
    if_req = 1'b1; if_addr = 32'h10; #1;
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL rmid_gnt got %b exp 1", if_gnt); end
    next_cycle(); if_req = 1'b0; #1;
    checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL rmid_pre got %b exp 1", mem_read); end
    rst = 1'b0; #1;
    checks++; if ({mem_read, busy, if_rvalid} !== 3'b000 || mem_addr !== 32'h0 || if_rdata !== 32'h0) begin
      errors++; $display("FAIL rmid_cleared got rd/busy/v=%b addr=%h data=%h exp 000 0 0", {mem_read, busy, if_rvalid}, mem_addr, if_rdata);
    end
    next_cycle(); rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      next_cycle(); #1;
      checks++; if (if_rvalid !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL rmid_no_rvalid c%0d got v=%b busy=%b exp 0 0", c, if_rvalid, busy);
      end
    end
    next_cycle();
    if_req = 1'b1; if_addr = 32'h10; #1;
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL rmid_regnt got %b exp 1", if_gnt); end
    next_cycle(); if_req = 1'b0;
    next_cycle();
    next_cycle(); #1;
    checks++; if (if_rvalid !== 1'b1 || if_rdata !== 32'h11223344) begin
      errors++; $display("FAIL rmid_recover got v=%b data=%h exp 1 11223344", if_rvalid, if_rdata);
    end
  endtask

  initial begin
    test_reset();
    test_fetch_read();
    test_store_load();
    test_simultaneous();
    test_back_to_back();
    test_starvation();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
